// File: rtl/irq_capture_pkg.sv
// Shared widths, state encoding and vector type for the interrupt capture front end.
package irq_capture_pkg;

    localparam int unsigned N_IRQ = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } state_e;

    typedef logic [N_IRQ-1:0] irq_vec_t;

endpackage

// File: rtl/irq_capture_if.sv
// Request/acknowledge bundle between the capture block and its consumer.
interface irq_capture_if;
    import irq_capture_pkg::*;

    irq_vec_t             irq_in;
    irq_vec_t             mask_in;
    irq_vec_t             req_out;
    logic                 req_valid;
    logic                 svc_ack;
    logic [IDX_W-1:0]     svc_idx;
    logic                 ack_err;
    irq_vec_t             overrun;
    logic                 ovr_clr;

    modport slave (
        input  irq_in, mask_in, svc_ack, svc_idx, ovr_clr,
        output req_out, req_valid, ack_err, overrun
    );

    modport master (
        output irq_in, mask_in, svc_ack, svc_idx, ovr_clr,
        input  req_out, req_valid, ack_err, overrun
    );
endinterface

// File: rtl/irq_capture_edge_det.sv
// Event detection: rising-edge or level events from the request lines.
module irq_edge_det
    import irq_capture_pkg::*;
#(
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic     clk,
    input  logic     rst_n,
    input  irq_vec_t irq_in,
    output irq_vec_t ev_c
);

    irq_vec_t prev_q;
    irq_vec_t prev_d;

    always_comb begin
        prev_d = irq_in;
        ev_c   = EDGE_MODE ? (irq_in & ~prev_q) : irq_in;
    end

    // Reset to zero so a line already high at reset release counts as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= '0;
        else        prev_q <= prev_d;
    end

endmodule

// File: rtl/irq_capture.sv
// Pending/overrun tracking and a frozen request snapshot held until acknowledged.
module irq_capture
    import irq_capture_pkg::*;
#(
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    irq_capture_if.slave  bus
);

    irq_vec_t ev_c;
    irq_vec_t clr_c;
    irq_vec_t ovr_set_c;

    state_e   state_q,     state_d;
    irq_vec_t pend_q,      pend_d;
    irq_vec_t snap_q,      snap_d;
    irq_vec_t ovr_q,       ovr_d;
    irq_vec_t req_out_q,   req_out_d;
    logic     req_valid_q, req_valid_d;
    logic     ack_err_q,   ack_err_d;

    irq_edge_det #(.EDGE_MODE(EDGE_MODE)) u_edge_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .irq_in (bus.irq_in),
        .ev_c   (ev_c)
    );

    // Next-state, snapshot, pending and overrun update.
    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        req_out_d   = req_out_q;
        req_valid_d = req_valid_q;
        ack_err_d   = 1'b0;
        clr_c       = '0;

        case (state_q)
            ST_IDLE: begin
                req_out_d   = '0;
                req_valid_d = 1'b0;
                if (|(pend_q & bus.mask_in)) begin
                    snap_d      = pend_q & bus.mask_in;
                    req_out_d   = pend_q & bus.mask_in;
                    req_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.svc_ack) begin
                    if (snap_q[bus.svc_idx]) begin
                        clr_c       = N_IRQ'(1) << bus.svc_idx;
                        req_out_d   = '0;
                        req_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        ack_err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new event on a bit wins over its clear in the same cycle.
        pend_d    = (pend_q & ~clr_c) | ev_c;
        ovr_set_c = EDGE_MODE ? (ev_c & pend_q & ~clr_c) : '0;
        ovr_d     = bus.ovr_clr ? '0 : (ovr_q | ovr_set_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pend_q      <= '0;
            snap_q      <= '0;
            ovr_q       <= '0;
            req_out_q   <= '0;
            req_valid_q <= 1'b0;
            ack_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            snap_q      <= snap_d;
            ovr_q       <= ovr_d;
            req_out_q   <= req_out_d;
            req_valid_q <= req_valid_d;
            ack_err_q   <= ack_err_d;
        end
    end

    assign bus.req_out   = req_out_q;
    assign bus.req_valid = req_valid_q;
    assign bus.ack_err   = ack_err_q;
    assign bus.overrun   = ovr_q;

endmodule
